// File: rtl/updown_counter_fsm.sv
// updown_counter_fsm
// Up/down counter sequencer. A rising edge on go loads the start value
// (0 when counting up, MAX_COUNT when counting down) and then steps the
// counter by one every DIV clocks until it reaches the end value. It then
// pulses done for one clock and returns to idle.
//
// Optional feature macro: UPDOWN_COUNTER_ABORT_EN adds the abort input,
// which cancels a run while counting.
//
// Ports:
//   clk    in   clock, all logic on its rising edge
//   rst    in   synchronous active-high reset
//   go     in   start request, acted on at its rising edge only
//   up     in   direction, sampled at start (1 = up, 0 = down)
//   abort  in   cancel while counting (UPDOWN_COUNTER_ABORT_EN only)
//   out    out  counter value (WIDTH bits)
//   busy   out  high while counting
//   done   out  one-cycle pulse after the end value has been held
module updown_counter_fsm #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_COUNT = 255,
    parameter int unsigned DIV       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             up,
`ifdef UPDOWN_COUNTER_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);
    localparam logic [PW-1:0]    P_LAST  = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             dir_q, dir_d;
    logic             go_prev_q;
    logic [PW-1:0]    pcnt_q, pcnt_d;

    logic             start;
    logic             tick;
    logic             abort_act;
    logic [WIDTH-1:0] end_val;

`ifdef UPDOWN_COUNTER_ABORT_EN
    assign abort_act = abort;
`else
    assign abort_act = 1'b0;
`endif

    assign start   = go & ~go_prev_q;
    assign tick    = (pcnt_q == P_LAST);
    assign end_val = dir_q ? MAX_VAL : '0;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_q     <= '0;
            dir_q     <= 1'b1;
            go_prev_q <= 1'b0;
            pcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            dir_q     <= dir_d;
            go_prev_q <= go;
            pcnt_q    <= pcnt_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        dir_d   = dir_q;
        pcnt_d  = pcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = up;
                    out_d   = up ? '0 : MAX_VAL;
                    pcnt_d  = '0;
                    state_d = COUNTING;
                end
            end
            COUNTING: begin
                if (abort_act) begin
                    // Cancel: value frozen, prescaler cleared, no done pulse
                    pcnt_d  = '0;
                    state_d = IDLE;
                end else if (tick) begin
                    pcnt_d = '0;
                    if (out_q == end_val) begin
                        state_d = DONE;
                    end else begin
                        out_d = dir_q ? out_q + WIDTH'(1) : out_q - WIDTH'(1);
                    end
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out  = out_q;
    assign busy = (state_q == COUNTING);
    assign done = (state_q == DONE);

endmodule
